// File: rtl/mem_responder_pkg.sv
// Shared types and helpers for the mem_responder line-memory slave.
package mem_responder_pkg;

    // Responder transaction phases.
    typedef enum logic [1:0] {
        M_IDLE  = 2'd0,
        M_WAIT  = 2'd1,
        M_BURST = 2'd2,
        M_DONE  = 2'd3
    } mem_state_t;

    // Latched transaction direction.
    typedef enum logic {
        MEM_READ  = 1'b0,
        MEM_WRITE = 1'b1
    } mem_op_t;

    // Number of byte-address bits that select a byte within one line.
    function automatic int unsigned line_offset_bits(input int unsigned lineitems,
                                                     input int unsigned wordbits);
        return $clog2(lineitems * wordbits / 8);
    endfunction

endpackage

// File: rtl/mem_line_array.sv
// Backing line storage: one word port, async read, synchronous write, no reset.
module mem_line_array #(
    parameter int unsigned WORDBITS = 32,
    parameter int unsigned AWIDTH   = 14
) (
    input  logic                i_clk,
    input  logic                i_we,
    input  logic [AWIDTH-1:0]   i_addr,
    input  logic [WORDBITS-1:0] i_wdata,
    output logic [WORDBITS-1:0] o_rdata_c
);

    logic [WORDBITS-1:0] r_mem [2**AWIDTH];

    // Word write; contents persist across reset.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata_c = r_mem[i_addr];

endmodule

// File: rtl/mem_responder.sv
// Main-memory stand-in: accepts line read/write requests, waits a fixed
// latency, then moves the line as a word-serial burst.
// Optional build macro: MEM_RESPONDER_STATS_EN adds rd_count/wr_count.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned ADDRBITS  = 32,
    parameter int unsigned WORDBITS  = 32,
    parameter int unsigned LINEITEMS = 16,
    parameter int unsigned MEMLINES  = 1024,
    parameter int unsigned LATENCY   = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                request,
    input  logic                write,
    input  logic [ADDRBITS-1:0] addr,
    input  logic [WORDBITS-1:0] wdata,
    input  logic                wvalid,
    output logic [WORDBITS-1:0] rdata,
    output logic                rvalid,
    output logic                ack,
    output logic                busy,
    output logic                done,
    output logic                error
`ifdef MEM_RESPONDER_STATS_EN
   ,output logic [31:0]         rd_count,
    output logic [31:0]         wr_count
`endif
);

    localparam int unsigned OFFBITS  = line_offset_bits(LINEITEMS, WORDBITS);
    localparam int unsigned IDXBITS  = ADDRBITS - OFFBITS;
    localparam int unsigned LINEBITS = $clog2(MEMLINES);
    localparam int unsigned WIDXBITS = $clog2(LINEITEMS);
    localparam int unsigned BEATBITS = WIDXBITS + 1;
    localparam int unsigned LATBITS  = $clog2(LATENCY) + 1;
    localparam int unsigned MEMAW    = LINEBITS + WIDXBITS;

    localparam logic [BEATBITS-1:0] LAST_BEAT = BEATBITS'(LINEITEMS - 1);
    localparam logic [LATBITS-1:0]  LAT_INIT  = LATBITS'(LATENCY - 1);

    mem_state_t          r_state, w_state_nxt;
    logic [LATBITS-1:0]  r_lat, w_lat_nxt;
    logic [BEATBITS-1:0] r_beat, w_beat_nxt;
    logic [LINEBITS-1:0] r_line, w_line_nxt;
    mem_op_t             r_op, w_op_nxt;
    logic                r_in_range, w_in_range_nxt;
    logic [WORDBITS-1:0] r_rdata, w_rdata_nxt;
    logic                r_rvalid, w_rvalid_nxt;
    logic                r_ack, w_ack_nxt;
    logic                r_busy, w_busy_nxt;
    logic                r_done, w_done_nxt;
    logic                r_error, w_error_nxt;

    logic [IDXBITS-1:0]  w_index;
    logic                w_in_range;
    logic [BEATBITS-1:0] w_beat_inc;
    logic [WIDXBITS-1:0] w_mem_beat;
    logic                w_mem_we;
    logic [WORDBITS-1:0] w_mem_rdata;
    logic [WORDBITS-1:0] w_rd_word;
    logic                w_unused_ok;

    assign w_index     = addr[ADDRBITS-1:OFFBITS];
    assign w_in_range  = (w_index >> LINEBITS) == '0;
    assign w_beat_inc  = r_beat + BEATBITS'(1);
    assign w_rd_word   = r_in_range ? w_mem_rdata : '0;
    assign w_unused_ok = ^{1'b0, addr[OFFBITS-1:0]};

    mem_line_array #(
        .WORDBITS (WORDBITS),
        .AWIDTH   (MEMAW)
    ) u_array (
        .i_clk     (clock),
        .i_we      (w_mem_we),
        .i_addr    ({r_line, w_mem_beat}),
        .i_wdata   (wdata),
        .o_rdata_c (w_mem_rdata)
    );

    // State and registered-output update.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= M_IDLE;
            r_lat      <= '0;
            r_beat     <= '0;
            r_line     <= '0;
            r_op       <= MEM_READ;
            r_in_range <= 1'b0;
            r_rdata    <= '0;
            r_rvalid   <= 1'b0;
            r_ack      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_lat      <= w_lat_nxt;
            r_beat     <= w_beat_nxt;
            r_line     <= w_line_nxt;
            r_op       <= w_op_nxt;
            r_in_range <= w_in_range_nxt;
            r_rdata    <= w_rdata_nxt;
            r_rvalid   <= w_rvalid_nxt;
            r_ack      <= w_ack_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_error    <= w_error_nxt;
        end
    end

    // Next state, storage port control and next values of the output registers.
    always_comb begin
        w_state_nxt    = r_state;
        w_lat_nxt      = r_lat;
        w_beat_nxt     = r_beat;
        w_line_nxt     = r_line;
        w_op_nxt       = r_op;
        w_in_range_nxt = r_in_range;
        w_rdata_nxt    = '0;
        w_rvalid_nxt   = 1'b0;
        w_ack_nxt      = 1'b0;
        w_done_nxt     = 1'b0;
        w_error_nxt    = 1'b0;
        w_mem_we       = 1'b0;
        w_mem_beat     = r_beat[WIDXBITS-1:0];

        unique case (r_state)
            M_IDLE: begin
                if (request) begin
                    w_state_nxt    = M_WAIT;
                    w_lat_nxt      = LAT_INIT;
                    w_beat_nxt     = '0;
                    w_line_nxt     = w_index[LINEBITS-1:0];
                    w_op_nxt       = write ? MEM_WRITE : MEM_READ;
                    w_in_range_nxt = w_in_range;
                    w_ack_nxt      = 1'b1;
                end
            end
            M_WAIT: begin
                if (r_lat == '0) begin
                    // Reads present beat 0 on the first BURST cycle.
                    w_state_nxt = M_BURST;
                    w_beat_nxt  = '0;
                    if (r_op == MEM_READ) begin
                        w_mem_beat   = '0;
                        w_rvalid_nxt = 1'b1;
                        w_rdata_nxt  = w_rd_word;
                    end
                end else begin
                    w_lat_nxt = r_lat - LATBITS'(1);
                end
            end
            M_BURST: begin
                if (r_op == MEM_READ) begin
                    if (r_beat == LAST_BEAT) begin
                        w_state_nxt = M_DONE;
                        w_done_nxt  = 1'b1;
                        w_error_nxt = ~r_in_range;
                    end else begin
                        w_beat_nxt   = w_beat_inc;
                        w_mem_beat   = w_beat_inc[WIDXBITS-1:0];
                        w_rvalid_nxt = 1'b1;
                        w_rdata_nxt  = w_rd_word;
                    end
                end else if (wvalid) begin
                    w_mem_we = r_in_range;
                    if (r_beat == LAST_BEAT) begin
                        w_state_nxt = M_DONE;
                        w_done_nxt  = 1'b1;
                        w_error_nxt = ~r_in_range;
                    end else begin
                        w_beat_nxt = w_beat_inc;
                    end
                end
            end
            M_DONE: begin
                w_state_nxt = M_IDLE;
            end
            default: begin
                w_state_nxt = M_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != M_IDLE);
    end

    assign rdata  = r_rdata;
    assign rvalid = r_rvalid;
    assign ack    = r_ack;
    assign busy   = r_busy;
    assign done   = r_done;
    assign error  = r_error;

`ifdef MEM_RESPONDER_STATS_EN
    logic [31:0] r_rd_count;
    logic [31:0] r_wr_count;

    // Saturating counts of completed in-range reads and writes.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rd_count <= '0;
            r_wr_count <= '0;
        end else if (r_state == M_DONE && r_in_range) begin
            if (r_op == MEM_READ) begin
                if (r_rd_count != 32'hFFFF_FFFF) begin
                    r_rd_count <= r_rd_count + 32'd1;
                end
            end else begin
                if (r_wr_count != 32'hFFFF_FFFF) begin
                    r_wr_count <= r_wr_count + 32'd1;
                end
            end
        end
    end

    assign rd_count = r_rd_count;
    assign wr_count = r_wr_count;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder against a line-level reference model.
module tb_mem_responder;

    localparam int LAT   = 4;
    localparam int ITEMS = 16;
    localparam int OFFB  = 6;
    localparam int LINES = 1024;

    logic        clock   = 1'b0;
    logic        reset   = 1'b0;
    logic        request = 1'b0;
    logic        write   = 1'b0;
    logic        wvalid  = 1'b0;
    logic [31:0] addr    = '0;
    logic [31:0] wdata   = '0;
    logic [31:0] rdata;
    logic        rvalid, ack, busy, done, error;
`ifdef MEM_RESPONDER_STATS_EN
    logic [31:0] rd_count, wr_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int exp_rd  = 0;
    int exp_wr  = 0;

    // Expected contents of every word the bench has written, keyed by line*ITEMS+word.
    logic [31:0] model [longint];

    always #5 clock = ~clock;

    mem_responder dut (
        .clock    (clock),
        .reset    (reset),
        .request  (request),
        .write    (write),
        .addr     (addr),
        .wdata    (wdata),
        .wvalid   (wvalid),
        .rdata    (rdata),
        .rvalid   (rvalid),
        .ack      (ack),
        .busy     (busy),
        .done     (done),
        .error    (error)
`ifdef MEM_RESPONDER_STATS_EN
       ,.rd_count (rd_count),
        .wr_count (wr_count)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_rdata"}, rdata, 0);
        chk({tag, "_rvalid"}, rvalid, 0);
        chk({tag, "_ack"}, ack, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
    endtask

    task automatic chk_stats(input string tag);
`ifdef MEM_RESPONDER_STATS_EN
        chk({tag, "_rd_count"}, rd_count, exp_rd);
        chk({tag, "_wr_count"}, wr_count, exp_wr);
`else
        chk({tag, "_stats_absent_busy"}, busy, 0);
`endif
    endtask

    // One transaction. stall_pct<0 selects the fixed 1,0,0 wvalid pattern;
    // base!=0 writes base+beat; abort_after>0 pulls reset after that many accepted beats.
    task automatic run_txn(input bit wr, input logic [31:0] a, input int stall_pct,
                           input bit poke, input logic [31:0] base, input int abort_after);
        longint idx;
        longint key;
        bit     inr;
        bit     ev;
        bit     fin;
        int     beats;
        int     done_cyc;
        int     k;
        idx      = longint'(a >> OFFB);
        inr      = idx < LINES;
        beats    = 0;
        done_cyc = wr ? -1 : LAT + ITEMS;
        k        = 0;
        fin      = 1'b0;
        @(negedge clock);
        request = 1'b1;
        write   = wr;
        addr    = a;
        wvalid  = 1'b0;
        for (int n = 0; n < 400 && !fin; n++) begin
            @(negedge clock);
            if (abort_after > 0 && beats == abort_after) begin
                reset   = 1'b0;
                request = 1'b0;
                wvalid  = 1'b0;
                #1;
                chk_quiet("abort");
                exp_rd = 0;
                exp_wr = 0;
                chk_stats("abort");
                fin = 1'b1;
            end else begin
                chk("ack", ack, n == 0);
                chk("busy", busy, 1);
                chk("done", done, n == done_cyc);
                if (!wr) begin
                    ev = (n >= LAT) && (n < LAT + ITEMS);
                    chk("rvalid", rvalid, ev);
                    if (ev) begin
                        key = idx * ITEMS + longint'(n - LAT);
                        if (!inr) chk("rdata_oor", rdata, 0);
                        else if (model.exists(key)) chk("rdata", rdata, model[key]);
                    end
                end else begin
                    chk("rvalid_on_write", rvalid, 0);
                end
                if (n == done_cyc) begin
                    chk("error", error, !inr);
                    if (inr) begin
                        if (wr) exp_wr++;
                        else    exp_rd++;
                    end
                    fin = 1'b1;
                end
                // Inputs for the edge closing cycle n; only burst-phase write beats matter.
                write   = 1'($urandom_range(1));
                addr    = $urandom;
                request = (poke && !fin) ? 1'($urandom_range(1)) : 1'b0;
                wdata   = $urandom;
                wvalid  = 1'($urandom_range(1));
                if (wr && n >= LAT && beats < ITEMS) begin
                    if (stall_pct < 0) wvalid = (k % 3 == 0);
                    else               wvalid = ($urandom_range(99) >= stall_pct);
                    k++;
                    if (base != 0) wdata = base + beats;
                    if (wvalid) begin
                        if (inr) model[idx * ITEMS + longint'(beats)] = wdata;
                        beats++;
                        if (beats == ITEMS) done_cyc = n + 1;
                    end
                end
            end
        end
        if (!fin) chk("txn_timeout", 0, 1);
        if (abort_after > 0) begin
            @(negedge clock);
            reset = 1'b1;
            for (int i = 0; i < 3; i++) begin
                @(negedge clock);
                chk("post_abort_done", done, 0);
                chk("post_abort_busy", busy, 0);
            end
        end else begin
            @(negedge clock);
            wvalid = 1'b0;
            chk("post_busy", busy, 0);
            chk("post_done", done, 0);
            chk("post_ack", ack, 0);
            chk_stats("post");
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        longint      ridx;
        int          pick;
        logic [31:0] ra;

        repeat (3) @(negedge clock);
        chk_quiet("in_reset");
        reset = 1'b1;
        @(negedge clock);
        chk_quiet("after_reset");
        chk_stats("after_reset");

        // Read of a never-written line: timing, count and completion.
        run_txn(1'b0, 32'h40, 0, 1'b0, 32'h0, 0);

        // Full write then readback, including an alias within the same line.
        run_txn(1'b1, 32'h80, 0, 1'b0, 32'hA000_0000, 0);
        run_txn(1'b0, 32'h80, 0, 1'b0, 32'h0, 0);
        run_txn(1'b0, 32'hBF, 0, 1'b0, 32'h0, 0);

        // Write with a periodic stall pattern, then readback.
        run_txn(1'b1, 32'hC0, -1, 1'b0, 32'hC000_0000, 0);
        run_txn(1'b0, 32'hC0, 0, 1'b0, 32'h0, 0);

        // Out-of-range read and write must not alias onto line 0.
        run_txn(1'b1, 32'h0, 0, 1'b0, 32'h5000_0000, 0);
        run_txn(1'b0, 32'h0001_0000, 0, 1'b0, 32'h0, 0);
        run_txn(1'b1, 32'h0001_0000, 0, 1'b0, 32'hDEAD_0000, 0);
        run_txn(1'b0, 32'h0, 0, 1'b0, 32'h0, 0);

        // Requests asserted while busy must be ignored.
        run_txn(1'b0, 32'h40, 0, 1'b1, 32'h0, 0);
        run_txn(1'b1, 32'h100, 30, 1'b1, 32'h0, 0);
        run_txn(1'b0, 32'h100, 0, 1'b1, 32'h0, 0);

        // Reset after 8 write beats leaves a partial line and no done.
        run_txn(1'b1, 32'h4000, 0, 1'b0, 32'h1111_0000, 0);
        run_txn(1'b1, 32'h4000, 0, 1'b0, 32'h2222_0000, 8);
        run_txn(1'b0, 32'h4000, 0, 1'b0, 32'h0, 0);

        // Randomized mix of lines, directions, stalls and busy-time requests.
        for (int t = 0; t < 30; t++) begin
            pick = $urandom_range(9);
            if (pick < 8)       ridx = longint'(pick);
            else if (pick == 8) ridx = 1023;
            else                ridx = 1024 + longint'($urandom_range(1000));
            ra = 32'(ridx << OFFB) | 32'($urandom_range(63));
            run_txn(1'($urandom_range(1)), ra, int'($urandom_range(60)),
                    1'($urandom_range(1)), 32'h0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
